// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes at acceptance.
// Each cycle performs one shift-add or restoring-divide step. The last BUSY cycle sign-corrects the result.
module alu_muldiv_iter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST     = CW'(W);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W - 1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Handshake: start is accepted on any rising edge where busy=0, which includes the FINISH cycle.
    // busy stays high for W+1 cycles. done pulses for one cycle, and ALUResult is valid in that cycle.
    // ALUResult then holds until the next result is produced.
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    araw_q, araw_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    result_q, result_d;

    logic [2:0]      op_in;
    logic            a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [W-1:0]    a_mag_in, b_mag_in;
    logic            dz_in, ovf_in, accept;

    always_comb begin
        op_in    = Operation[2:0];
        a_sgn_in = op_in[2] ? ~op_in[0] : (op_in != OP_MULHU);
        b_sgn_in = op_in[2] ? ~op_in[0] : ((op_in == OP_MUL) || (op_in == OP_MULH));
        a_neg_in = a_sgn_in & SrcA[W-1];
        b_neg_in = b_sgn_in & SrcB[W-1];
        a_mag_in = a_neg_in ? -SrcA : SrcA;
        b_mag_in = b_neg_in ? -SrcB : SrcB;
        dz_in    = (SrcB == '0);
        ovf_in   = op_in[2] & ~op_in[0] & (SrcA == MOST_NEG) & (SrcB == '1);
        accept   = start & (state_q != BUSY);
    end

    // One iteration step. hi:lo is the product shift register for multiply,
    // or remainder:quotient for divide.
    logic [W:0]      mul_sum;
    logic [W:0]      div_sh;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [W-1:0]    iter_hi, iter_lo;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
        div_sh   = {hi_q, lo_q[W-1]};
        div_ge   = (div_sh >= {1'b0, m_q});
        div_diff = div_sh[W-1:0] - m_q;
        if (op_q[2]) begin
            iter_hi = div_ge ? div_diff : div_sh[W-1:0];
            iter_lo = {lo_q[W-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    logic [2*W-1:0]  prod, prod_c;
    logic [W-1:0]    quot_c, rem_c, final_res;

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_c = neg_q ? -prod : prod;
        quot_c = neg_q ? -lo_q : lo_q;
        rem_c  = rneg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       final_res = prod_c[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_c[2*W-1:W];
            OP_DIV, OP_DIVU:              final_res = dz_q ? '1 : (ovf_q ? MOST_NEG : quot_c);
            OP_REM, OP_REMU:              final_res = dz_q ? araw_q : (ovf_q ? '0 : rem_c);
            default:                      final_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        araw_d   = araw_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    state_d  = FINISH;
                    result_d = final_res;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    hi_d  = iter_hi;
                    lo_d  = iter_lo;
                end
            end
            FINISH: begin
                state_d = start ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cnt_d  = '0;
            op_d   = op_in;
            neg_d  = a_neg_in ^ b_neg_in;
            rneg_d = a_neg_in;
            dz_d   = dz_in;
            ovf_d  = ovf_in;
            araw_d = SrcA;
            hi_d   = '0;
            lo_d   = op_in[2] ? a_mag_in : b_mag_in;
            m_d    = op_in[2] ? b_mag_in : a_mag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            araw_q   <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            araw_q   <= araw_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign done      = (state_q == FINISH);
    assign ALUResult = result_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Bench for alu_muldiv_iter: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_muldiv_iter;
    localparam int W = 32;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   Operation;
    logic [W-1:0] SrcA, SrcB;
    logic         busy, done;
    logic [W-1:0] ALUResult;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[12];

    alu_muldiv_iter #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .start(start), .Operation(Operation),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .ALUResult(ALUResult)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic with the RV32M special cases.
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = '0;
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == '0) return '1;
                if (a == MOST_NEG && b == '1) return MOST_NEG;
                p = sa / sb; return p[31:0];
            end
            OP_REM: begin
                if (b == '0) return a;
                if (a == MOST_NEG && b == '1) return '0;
                p = sa % sb; return p[31:0];
            end
            OP_DIVU: begin
                if (b == '0) return '1;
                p = ua / ub; return p[31:0];
            end
            default: begin
                if (b == '0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
    endtask

    // Called at the negedge where start is driven; returns at the negedge after the accepting edge.
    task automatic accept_cycle();
        @(negedge clk);
        start     = 1'b0;
        check("busy_rise", {31'b0, busy}, 32'd1);
        check("done_low_in_busy", {31'b0, done}, 32'd0);
        Operation = 3'($urandom_range(7, 0));
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    task automatic wait_done(input int lat0, output logic [W-1:0] res, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        res = ALUResult;
    endtask

    task automatic run_single(input string name, input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] exp);
        logic [W-1:0] res;
        int lat;
        @(negedge clk);
        start_op(op, a, b);
        accept_cycle();
        wait_done(0, res, lat);
        check(name, res, exp);
        check({name, "_latency"}, W'(lat), W'(W + 1));
        @(negedge clk);
        check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({name, "_hold"}, ALUResult, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res, a, b, exp, exp_mul;
        logic [2:0]   op;
        int lat, done_cnt;
        bit at_finish;

        vecs[0]  = '{OP_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vecs[2]  = '{OP_REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd14};
        vecs[4]  = '{OP_REMU,  32'd100,      32'd7,        32'd2};
        vecs[5]  = '{OP_DIV,   32'h12345678, 32'd0,        32'hFFFFFFFF};
        vecs[6]  = '{OP_DIVU,  32'h12345678, 32'd0,        32'hFFFFFFFF};
        vecs[7]  = '{OP_REM,   32'h12345678, 32'd0,        32'h12345678};
        vecs[8]  = '{OP_REMU,  32'h12345678, 32'd0,        32'h12345678};
        vecs[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[10] = '{OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};

        // Reset state, and reset taking priority over a simultaneous start.
        reset = 1'b1; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", ALUResult, 32'd0);
        start_op(OP_MUL, 32'd3, 32'd4);
        @(negedge clk);
        check("reset_over_start", {31'b0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Back-to-back high-half multiplies, each started during the previous FINISH cycle.
        @(negedge clk);
        start_op(OP_MULH, 32'h80000000, 32'hFFFFFFFF);
        accept_cycle();
        wait_done(0, res, lat);
        check("b2b_mulh", res, 32'h00000000);
        start_op(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF);
        accept_cycle();
        wait_done(0, res, lat);
        check("b2b_mulhsu", res, 32'h80000000);
        check("b2b_mulhsu_latency", W'(lat), W'(W + 1));
        start_op(OP_MULHU, 32'h80000000, 32'hFFFFFFFF);
        accept_cycle();
        wait_done(0, res, lat);
        check("b2b_mulhu", res, 32'h7FFFFFFF);

        // A start pulse while busy is ignored.
        @(negedge clk);
        exp_mul = ref_model(OP_MUL, 32'd1234, 32'hFFFFD000);
        start_op(OP_MUL, 32'd1234, 32'hFFFFD000);
        accept_cycle();
        repeat (4) @(negedge clk);
        start_op(OP_DIVU, 32'd999, 32'd3);
        @(negedge clk);
        start = 1'b0;
        wait_done(5, res, lat);
        check("ignore_start_result", res, exp_mul);
        check("ignore_start_latency", W'(lat), W'(W + 1));

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        start_op(OP_DIV, 32'hFFFF0000, 32'd3);
        accept_cycle();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", ALUResult, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", W'(done_cnt), 32'd0);
        run_single("after_reset", OP_DIVU, 32'd100, 32'd7, 32'd14);

        // Randomized operations, some chained directly out of FINISH.
        at_finish = 1'b0;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MOST_NEG; b = '1; end
                2: a = MOST_NEG;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp_q.push_back(ref_model(op, a, b));
            if (!(at_finish && $urandom_range(0, 1) == 1)) @(negedge clk);
            start_op(op, a, b);
            accept_cycle();
            wait_done(0, res, lat);
            exp = exp_q.pop_front();
            check($sformatf("rand%0d_op%0d", i, op), res, exp);
            check($sformatf("rand%0d_latency", i), W'(lat), W'(W + 1));
            at_finish = 1'b1;
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
